// File: rtl/sha3_pkg.sv
// Shared SHA-3 sponge constants, FSM state encoding and small helpers for the
// block padder. Build option: BLOCK_PADDER_KECCAK_PAD_EN selects the original
// Keccak domain byte (0x01) instead of the FIPS-202 SHA3 byte (0x06).
package sha3_pkg;

    localparam int unsigned RATE_BYTES = 136;
    localparam int unsigned LANE_W     = 64;
    localparam int unsigned LANE_BYTES = LANE_W / 8;
    localparam int unsigned NBYTES_W   = 4;

`ifdef BLOCK_PADDER_KECCAK_PAD_EN
    localparam logic [7:0] PAD_DOMAIN = 8'h01;
`else
    localparam logic [7:0] PAD_DOMAIN = 8'h06;
`endif

    localparam logic [7:0] PAD_FINAL = 8'h80;

    // Padder FSM state encoding
    typedef logic [1:0] state_t;

    localparam state_t FILL     = 2'd0;
    localparam state_t PAD_ONLY = 2'd1;
    localparam state_t HOLD     = 2'd2;

    // Byte counts above a full lane are treated as a full lane
    function automatic logic [NBYTES_W-1:0] clamp_nbytes(input logic [NBYTES_W-1:0] n);
        return (n > NBYTES_W'(LANE_BYTES)) ? NBYTES_W'(LANE_BYTES) : n;
    endfunction

endpackage : sha3_pkg

// File: rtl/lane_masker.sv
// Combinational lane conditioner: zeroes bytes at or above the valid count and
// inserts the domain pad byte right after the last valid byte when it fits in
// this lane. pad_carry_c flags a full lane, where the pad byte lands in the
// next lane instead.
module lane_masker
    import sha3_pkg::*;
(
    input  logic [LANE_W-1:0]   data,
    input  logic [NBYTES_W-1:0] nbytes,
    output logic [LANE_W-1:0]   masked_c,
    output logic [LANE_W-1:0]   padded_c,
    output logic                pad_carry_c
);

    logic [NBYTES_W-1:0] nb;

    assign nb = clamp_nbytes(nbytes);

    // Byte mask followed by in-lane domain byte insertion
    always_comb begin
        masked_c    = '0;
        padded_c    = '0;
        pad_carry_c = (nb == NBYTES_W'(LANE_BYTES));
        for (int j = 0; j < int'(LANE_BYTES); j++) begin
            if (NBYTES_W'(j) < nb) begin
                masked_c[j*8 +: 8] = data[j*8 +: 8];
            end
        end
        padded_c = masked_c;
        for (int j = 0; j < int'(LANE_BYTES); j++) begin
            if (NBYTES_W'(j) == nb) begin
                padded_c[j*8 +: 8] = PAD_DOMAIN;
            end
        end
    end

endmodule : lane_masker

// File: rtl/block_padder.sv
// SHA-3 rate block assembler and padder. Collects 64-bit message lanes into a
// RATE_LANES-lane block, applies pad10*1 with the domain byte on the final
// word, and holds each block until the absorb stage takes it. A message that
// exactly fills a block gets a second, pad-only block.
// Build option: BLOCK_PADDER_KECCAK_PAD_EN (domain byte 0x01 instead of 0x06).
module block_padder
    import sha3_pkg::*;
#(
    parameter int unsigned RATE_LANES = 17
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic [LANE_W-1:0]            in_data,
    input  logic                         in_valid,
    input  logic                         in_last,
    input  logic [NBYTES_W-1:0]          in_nbytes,
    output logic                         in_ready,
    output logic [RATE_LANES*LANE_W-1:0] block,
    output logic                         block_valid,
    output logic                         block_last,
    input  logic                         block_ready
);

    localparam int unsigned BLOCK_W = RATE_LANES * LANE_W;
    localparam int unsigned CNT_W   = 5;
    localparam int unsigned POS_W   = CNT_W + 3;

    localparam logic [CNT_W-1:0] LAST_LANE = CNT_W'(RATE_LANES - 1);
    localparam logic [POS_W-1:0] FULL_POS  = POS_W'(RATE_LANES * LANE_BYTES);

    state_t               state_q;
    state_t               state_d;
    logic [CNT_W-1:0]     lane_cnt_q;
    logic [CNT_W-1:0]     lane_cnt_d;
    logic [BLOCK_W-1:0]   block_q;
    logic [BLOCK_W-1:0]   block_d;
    logic                 block_last_q;
    logic                 block_last_d;
    logic                 pad_pend_q;
    logic                 pad_pend_d;

    logic [LANE_W-1:0]    word_masked;
    logic [LANE_W-1:0]    word_padded;
    logic                 word_carry;
    logic [POS_W-1:0]     pad_pos;
    logic                 pad_full;

    lane_masker u_lane_masker (
        .data        (in_data),
        .nbytes      (in_nbytes),
        .masked_c    (word_masked),
        .padded_c    (word_padded),
        .pad_carry_c (word_carry)
    );

    // Byte offset of the pad byte if the current word ends the message
    assign pad_pos  = POS_W'({lane_cnt_q, 3'b000}) + POS_W'(clamp_nbytes(in_nbytes));
    assign pad_full = (pad_pos == FULL_POS);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= FILL;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and datapath next values
    always_comb begin
        state_d      = state_q;
        lane_cnt_d   = lane_cnt_q;
        block_d      = block_q;
        block_last_d = block_last_q;
        pad_pend_d   = pad_pend_q;

        case (state_q)
            FILL: begin
                if (in_valid) begin
                    for (int i = 0; i < int'(RATE_LANES); i++) begin
                        if (lane_cnt_q == CNT_W'(i)) begin
                            block_d[i*LANE_W +: LANE_W] = in_last ? word_padded : word_masked;
                        end
                    end
                    if (in_last) begin
                        lane_cnt_d = '0;
                        state_d    = HOLD;
                        if (pad_full) begin
                            // Message filled the block exactly; padding goes in a block of its own
                            block_last_d = 1'b0;
                            pad_pend_d   = 1'b1;
                        end else begin
                            // Full final lane: domain byte starts the next (still empty) lane
                            if (word_carry) begin
                                for (int i = 1; i < int'(RATE_LANES); i++) begin
                                    if (lane_cnt_q == CNT_W'(i - 1)) begin
                                        block_d[i*LANE_W +: 8] = PAD_DOMAIN;
                                    end
                                end
                            end
                            block_d[BLOCK_W-1 -: 8] = block_d[BLOCK_W-1 -: 8] | PAD_FINAL;
                            block_last_d            = 1'b1;
                        end
                    end else if (lane_cnt_q == LAST_LANE) begin
                        lane_cnt_d   = '0;
                        block_last_d = 1'b0;
                        state_d      = HOLD;
                    end else begin
                        lane_cnt_d = lane_cnt_q + CNT_W'(1);
                    end
                end
            end

            PAD_ONLY: begin
                block_d                 = '0;
                block_d[7:0]            = PAD_DOMAIN;
                block_d[BLOCK_W-1 -: 8] = PAD_FINAL;
                block_last_d            = 1'b1;
                pad_pend_d              = 1'b0;
                state_d                 = HOLD;
            end

            HOLD: begin
                if (block_ready) begin
                    block_d      = '0;
                    block_last_d = 1'b0;
                    state_d      = pad_pend_q ? PAD_ONLY : FILL;
                end
            end

            default: begin
                state_d = FILL;
            end
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            lane_cnt_q   <= '0;
            block_q      <= '0;
            block_last_q <= 1'b0;
            pad_pend_q   <= 1'b0;
        end else begin
            lane_cnt_q   <= lane_cnt_d;
            block_q      <= block_d;
            block_last_q <= block_last_d;
            pad_pend_q   <= pad_pend_d;
        end
    end

    // Outputs are direct views of registered state; in_ready is also held low in reset
    assign block       = block_q;
    assign block_last  = block_last_q;
    assign block_valid = (state_q == HOLD);
    assign in_ready    = reset & (state_q == FILL);

endmodule : block_padder

// File: tb/tb_block_padder.sv
// Directed bench for block_padder: reset behaviour, empty / 135 / 136 byte
// messages, back-pressure stall, byte-count clamping and mid-message reset.
module tb_block_padder;

    localparam int BW = 1088;

`ifdef BLOCK_PADDER_KECCAK_PAD_EN
    localparam logic [7:0] DOM      = 8'h01;
    localparam logic [7:0] B135_P135 = 8'h81;
`else
    localparam logic [7:0] DOM      = 8'h06;
    localparam logic [7:0] B135_P135 = 8'h86;
`endif

    logic          clk;
    logic          reset;
    logic [63:0]   in_data;
    logic          in_valid;
    logic          in_last;
    logic [3:0]    in_nbytes;
    logic          in_ready;
    logic [BW-1:0] block;
    logic          block_valid;
    logic          block_last;
    logic          block_ready;

    int            checks = 0;
    int            errors = 0;
    int            hs_cnt = 0;
    logic [7:0]    msg [0:143];
    logic [BW-1:0] exp_blk;

    block_padder #(.RATE_LANES(17)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_last     (in_last),
        .in_nbytes   (in_nbytes),
        .in_ready    (in_ready),
        .block       (block),
        .block_valid (block_valid),
        .block_last  (block_last),
        .block_ready (block_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (block_valid && block_ready) hs_cnt <= hs_cnt + 1;
    end

    initial begin
        #200000;
        $error("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_blk(input string tag, input logic [BW-1:0] exp);
        int first;
        first = 0;
        for (int k = BW/8 - 1; k >= 0; k--) begin
            if (block[8*k +: 8] !== exp[8*k +: 8]) first = k;
        end
        checks++;
        assert (block === exp) else begin
            errors++;
            $error("FAIL %s: byte %0d observed %02h expected %02h", tag, first,
                   block[8*first +: 8], exp[8*first +: 8]);
        end
    endtask

    // Expected block: message bytes, then optional pad10*1 with domain byte
    task automatic build_exp(input int len, input bit pad);
        exp_blk = '0;
        for (int k = 0; k < len; k++) exp_blk[8*k +: 8] = msg[k];
        if (pad) begin
            if (len < 136) exp_blk[8*len +: 8] = exp_blk[8*len +: 8] | DOM;
            exp_blk[BW-1 -: 8] = exp_blk[BW-1 -: 8] | 8'h80;
        end
    endtask

    // Starts and ends at a negedge
    task automatic send_word(input logic [63:0] d, input logic [3:0] nb, input bit last);
        in_data   = d;
        in_nbytes = nb;
        in_last   = last;
        in_valid  = 1'b1;
        #1;
        chk("in_ready_fill", 64'(in_ready), 64'd1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
    endtask

    task automatic send_msg(input int len, input bit last);
        int          nw;
        logic [63:0] d;
        logic [3:0]  nb;
        if (last) nw = (len == 0) ? 1 : (len + 7) / 8;
        else      nw = len / 8;
        for (int w = 0; w < nw; w++) begin
            for (int j = 0; j < 8; j++) begin
                d[8*j +: 8] = (8*w + j < len) ? msg[8*w + j] : 8'hEE;
            end
            nb = (last && w == nw - 1) ? 4'(len - 8*w) : 4'd8;
            send_word(d, nb, last && (w == nw - 1));
        end
    endtask

    task automatic wait_valid(input string tag, input int max_cycles);
        int n;
        n = 0;
        while (block_valid !== 1'b1 && n < max_cycles) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 64'(block_valid), 64'd1);
    endtask

    task automatic handshake(input string tag);
        block_ready = 1'b1;
        @(posedge clk);
        #1;
        block_ready = 1'b0;
        @(negedge clk);
        chk(tag, 64'(block_valid), 64'd0);
    endtask

    initial begin
        int bad;
        int hs0;
        reset       = 1'b0;
        in_data     = '0;
        in_valid    = 1'b0;
        in_last     = 1'b0;
        in_nbytes   = '0;
        block_ready = 1'b0;
        for (int k = 0; k < 144; k++) msg[k] = '0;

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", 64'(in_ready), 64'd0);
        chk("rst_valid", 64'(block_valid), 64'd0);
        chk("rst_last", 64'(block_last), 64'd0);
        chk_blk("rst_block", '0);
        reset = 1'b1;
        #1;
        chk("ready_after_release", 64'(in_ready), 64'd1);
        @(negedge clk);

        // Empty message
        build_exp(0, 1'b1);
        send_msg(0, 1'b1);
        chk("empty_latency", 64'(block_valid), 64'd1);
        chk("empty_last", 64'(block_last), 64'd1);
        chk("empty_byte0", 64'(block[7:0]), 64'(DOM));
        chk("empty_byte135", 64'(block[1087:1080]), 64'h80);
        chk_blk("empty_blk", exp_blk);
        chk("hold_in_ready", 64'(in_ready), 64'd0);
        handshake("empty_valid_fall");

        // 135-byte message 0x00..0x86
        for (int k = 0; k < 144; k++) msg[k] = 8'(k);
        build_exp(135, 1'b1);
        send_msg(135, 1'b1);
        chk("m135_valid", 64'(block_valid), 64'd1);
        chk("m135_last", 64'(block_last), 64'd1);
        chk("m135_byte134", 64'(block[1079:1072]), 64'h86);
        chk("m135_byte135", 64'(block[1087:1080]), 64'(B135_P135));
        chk_blk("m135_blk", exp_blk);
        handshake("m135_valid_fall");

        // 136-byte message: data block then pad-only block
        for (int k = 0; k < 144; k++) msg[k] = 8'(k) ^ 8'hA5;
        build_exp(136, 1'b0);
        send_msg(136, 1'b1);
        chk("m136a_valid", 64'(block_valid), 64'd1);
        chk("m136a_last", 64'(block_last), 64'd0);
        chk_blk("m136a_blk", exp_blk);
        handshake("m136a_valid_fall");
        build_exp(0, 1'b1);
        wait_valid("m136b_valid", 5);
        chk("m136b_last", 64'(block_last), 64'd1);
        chk_blk("m136b_blk", exp_blk);
        handshake("m136b_valid_fall");
        chk("m136_back_to_fill", 64'(in_ready), 64'd1);

        // Full non-final block held under back-pressure with junk on the input
        for (int k = 0; k < 144; k++) msg[k] = 8'(3*k + 1);
        build_exp(136, 1'b0);
        send_msg(136, 1'b0);
        chk("stall_valid", 64'(block_valid), 64'd1);
        chk("stall_last", 64'(block_last), 64'd0);
        in_data   = 64'hDEAD_BEEF_0BAD_F00D;
        in_nbytes = 4'd3;
        in_last   = 1'b1;
        in_valid  = 1'b1;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (block !== exp_blk || block_valid !== 1'b1 || block_last !== 1'b0 || in_ready !== 1'b0)
                bad++;
        end
        chk("stall_stable_cycles", 64'(bad), 64'd0);
        in_valid = 1'b0;
        in_last  = 1'b0;
        hs0 = hs_cnt;
        block_ready = 1'b1;
        repeat (3) @(negedge clk);
        block_ready = 1'b0;
        chk("stall_one_handshake", 64'(hs_cnt - hs0), 64'd1);
        chk("stall_valid_low", 64'(block_valid), 64'd0);

        // "abc" after the stalled block starts in lane 0
        msg[0] = 8'h61; msg[1] = 8'h62; msg[2] = 8'h63;
        build_exp(3, 1'b1);
        send_msg(3, 1'b1);
        chk("abc_byte3", 64'(block[31:24]), 64'(DOM));
        chk("abc_last", 64'(block_last), 64'd1);
        chk_blk("abc_blk", exp_blk);
        handshake("abc_valid_fall");

        // Final word with nbytes=15 is a full lane; pad starts lane 1
        for (int k = 0; k < 8; k++) msg[k] = 8'(8'h11 * (k + 1));
        build_exp(8, 1'b1);
        send_word(64'h8877_6655_4433_2211, 4'hF, 1'b1);
        chk("nb15_byte8", 64'(block[71:64]), 64'(DOM));
        chk_blk("nb15_blk", exp_blk);
        handshake("nb15_valid_fall");

        // Reset after five accepted words discards the partial block
        for (int k = 0; k < 144; k++) msg[k] = 8'hC0 + 8'(k);
        send_msg(40, 1'b0);
        reset = 1'b0;
        #1;
        chk("midrst_in_ready", 64'(in_ready), 64'd0);
        chk("midrst_valid", 64'(block_valid), 64'd0);
        chk("midrst_last", 64'(block_last), 64'd0);
        chk_blk("midrst_block", '0);
        @(negedge clk);
        reset = 1'b1;
        bad = 0;
        repeat (4) begin
            @(negedge clk);
            if (block_valid !== 1'b0) bad++;
        end
        chk("midrst_no_output", 64'(bad), 64'd0);
        build_exp(0, 1'b1);
        send_msg(0, 1'b1);
        chk("midrst_empty_valid", 64'(block_valid), 64'd1);
        chk("midrst_empty_last", 64'(block_last), 64'd1);
        chk_blk("midrst_empty_blk", exp_blk);
        handshake("midrst_valid_fall");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_block_padder
